muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the execute stage. It takes operands read from the register file, computes one of the eight M-extension operations over a fixed multi-cycle latency, and presents a one-cycle write-back (`result`, `rd_addr_out`, `wb_we`) that drives the register file write port (`rd_data`, `rd_addr`, `we`). While it works, `busy` tells the hazard/stall logic to hold the pipeline.

---
 rtl/muldiv_unit_if.sv | 26 ++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide unit.
// The pipeline side drives operands and start; the unit returns status and write-back.
interface muldiv_unit_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [2:0]      funct3;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr_in;
   logic            busy;
   logic            done;
   logic            wb_we;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_addr_out;

   modport master (
      output start, funct3, rs1_data, rs2_data, rd_addr_in,
      input  busy, done, wb_we, result, rd_addr_out
   );

   modport slave (
      input  start, funct3, rs1_data, rs2_data, rd_addr_in,
      output busy, done, wb_we, result, rd_addr_out
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one radix-2 step per cycle on operand magnitudes,
// sign correction and result selection folded into the final step.
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   muldiv_unit_if.slave bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t            r_state, w_state_nx;
   logic [CW-1:0]     r_cnt;
   logic [2:0]        r_op;
   logic [4:0]        r_rd;
   logic [XLEN-1:0]   r_hi, r_lo, r_b, r_result;
   logic              r_neg_res, r_neg_rem;

   logic              w_accept, w_last;
   logic              w_a_sgn, w_b_sgn, w_neg_res;
   logic [XLEN-1:0]   w_a_mag, w_b_mag;
   logic [XLEN:0]     w_sum, w_trial;
   logic [XLEN-1:0]   w_hi_nx, w_lo_nx, w_res;
   logic [2*XLEN-1:0] w_prod;

   function automatic logic [XLEN-1:0] cneg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   function automatic logic [2*XLEN-1:0] cneg2(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   assign w_accept = bus.start && (r_state != CALC);
   assign w_last   = (r_state == CALC) && (r_cnt == CW'(XLEN-1));

   // Operand sign handling: only MULH/MULHSU/DIV/REM treat rs1 as signed, MULH/DIV/REM rs2.
   always_comb begin
      w_a_sgn   = bus.rs1_data[XLEN-1] && (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 ||
                                           bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
      w_b_sgn   = bus.rs2_data[XLEN-1] && (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 ||
                                           bus.funct3 == 3'b110);
      w_a_mag   = cneg(bus.rs1_data, w_a_sgn);
      w_b_mag   = cneg(bus.rs2_data, w_b_sgn);
      // A zero divisor must leave the all-ones quotient uncorrected.
      w_neg_res = (w_a_sgn ^ w_b_sgn) && (!bus.funct3[2] || (bus.rs2_data != '0));
   end

   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_trial = {r_hi, r_lo[XLEN-1]} - {1'b0, r_b};
      if (r_op[2]) begin
         if (!w_trial[XLEN]) begin
            w_hi_nx = w_trial[XLEN-1:0];
            w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
         end else begin
            w_hi_nx = {r_hi[XLEN-2:0], r_lo[XLEN-1]};
            w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
         end
      end else begin
         w_hi_nx = w_sum[XLEN:1];
         w_lo_nx = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   always_comb begin
      w_prod = cneg2({w_hi_nx, w_lo_nx}, r_neg_res);
      case (r_op)
         3'b000:                 w_res = w_prod[XLEN-1:0];
         3'b001, 3'b010, 3'b011: w_res = w_prod[2*XLEN-1:XLEN];
         3'b100, 3'b101:         w_res = cneg(w_lo_nx, r_neg_res);
         default:                w_res = cneg(w_hi_nx, r_neg_rem);
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_state_nx;
   end

   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_state_nx = CALC;
         CALC:    if (w_last)    w_state_nx = DONE;
         DONE:    w_state_nx = bus.start ? CALC : IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt    <= '0;
         r_rd     <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_cnt <= '0;
            r_rd  <= bus.rd_addr_in;
         end else if (r_state == CALC) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_last) r_result <= w_res;
      end
   end

   // Multiply: r_lo holds the multiplier, r_b the multiplicand. Divide: r_lo the dividend, r_b the divisor.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_op      <= bus.funct3;
         r_hi      <= '0;
         r_lo      <= bus.funct3[2] ? w_a_mag : w_b_mag;
         r_b       <= bus.funct3[2] ? w_b_mag : w_a_mag;
         r_neg_res <= w_neg_res;
         r_neg_rem <= w_a_sgn;
      end else if (r_state == CALC) begin
         r_hi <= w_hi_nx;
         r_lo <= w_lo_nx;
      end
   end

   assign bus.busy        = (r_state == CALC);
   assign bus.done        = (r_state == DONE);
   assign bus.wb_we       = (r_state == DONE);
   assign bus.result      = r_result;
   assign bus.rd_addr_out = r_rd;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of single operations plus
// hand-written sequences for dropped starts, back-to-back issue and mid-operation reset.
module tb_muldiv_unit;
   logic clk = 1'b0;
   logic rst;

   muldiv_unit_if #(.XLEN(32)) bus ();

   muldiv_unit #(.XLEN(32)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   int          nd;
   int          dc[4];
   logic [31:0] dr[4];
   logic [4:0]  dt[4];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t);
      bus.start      = s;
      bus.funct3     = f;
      bus.rs1_data   = a;
      bus.rs2_data   = b;
      bus.rd_addr_in = t;
   endtask

   task automatic record(input int c);
      if (bus.done) begin
         if (nd < 4) begin
            dc[nd] = c;
            dr[nd] = bus.result;
            dt[nd] = bus.rd_addr_out;
         end
         nd++;
      end
   endtask

   task automatic run_op(input int idx, input vec_t v);
      int n;
      logic [4:0] tag;
      string nm;
      tag = 5'(idx + 1);
      nm  = $sformatf("vec%0d_f3=%0d", idx, v.f3);
      drive(1'b1, v.f3, v.a, v.b, tag);
      tick();
      // Scrambled operands after the start cycle must not matter.
      drive(1'b0, ~v.f3, ~v.a, v.b ^ 32'h5A5A_A5A5, ~tag);
      n = 1;
      chk({nm, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && n < 100) begin
         tick();
         n++;
      end
      chk({nm, "_latency"}, 32'(n), 32'd33);
      chk({nm, "_result"}, bus.result, v.exp);
      chk({nm, "_rd"}, 32'(bus.rd_addr_out), 32'(tag));
      chk({nm, "_wb_we"}, 32'(bus.wb_we), 32'd1);
      tick();
      chk({nm, "_done_width"}, 32'(bus.done), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs.push_back('{3'b000, 32'd7,          32'hFFFF_FFF9, 32'hFFFF_FFCF});
      vecs.push_back('{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE});
      vecs.push_back('{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000});
      vecs.push_back('{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF});
      vecs.push_back('{3'b001, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF});
      vecs.push_back('{3'b001, 32'hFFFF_FFFF,  32'd3,         32'hFFFF_FFFF});
      vecs.push_back('{3'b000, 32'h0001_0001,  32'h0001_0001, 32'h0002_0001});
      vecs.push_back('{3'b011, 32'h0001_0001,  32'h0001_0001, 32'h0000_0001});
      vecs.push_back('{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD});
      vecs.push_back('{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF});
      vecs.push_back('{3'b101, 32'hFFFF_FFFE,  32'd2,         32'h7FFF_FFFF});
      vecs.push_back('{3'b111, 32'd10,         32'd3,         32'd1});
      vecs.push_back('{3'b100, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2});
      vecs.push_back('{3'b110, 32'd100,        32'hFFFF_FFF9, 32'd2});
      vecs.push_back('{3'b101, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});
      vecs.push_back('{3'b111, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{3'b100, 32'd5,          32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{3'b110, 32'd5,          32'd0,         32'd5});
      vecs.push_back('{3'b100, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB});
      vecs.push_back('{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF});
      vecs.push_back('{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000});
      vecs.push_back('{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0});

      rst = 1'b1;
      drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_busy",   32'(bus.busy),        32'd0);
      chk("reset_done",   32'(bus.done),        32'd0);
      chk("reset_wb_we",  32'(bus.wb_we),       32'd0);
      chk("reset_result", bus.result,           32'd0);
      chk("reset_rd",     32'(bus.rd_addr_out), 32'd0);
      tick();

      foreach (vecs[i]) run_op(i, vecs[i]);

      // Dropped start while busy, then back-to-back start in the DONE cycle.
      nd = 0;
      drive(1'b1, 3'b100, 32'd100, 32'd7, 5'd3);
      for (int c = 1; c <= 70; c++) begin
         tick();
         record(c);
         if (c == 5)       drive(1'b1, 3'b101, 32'h0000_FFFF, 32'd2, 5'd9);
         else if (c == 33) drive(1'b1, 3'b110, 32'd100, 32'd7, 5'd17);
         else              drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      end
      chk("b2b_done_count", 32'(nd), 32'd2);
      chk("b2b_first_cycle", 32'(dc[0]), 32'd33);
      chk("b2b_first_result", dr[0], 32'd14);
      chk("b2b_first_rd", 32'(dt[0]), 32'd3);
      chk("b2b_second_cycle", 32'(dc[1]), 32'd66);
      chk("b2b_second_result", dr[1], 32'd2);
      chk("b2b_second_rd", 32'(dt[1]), 32'd17);

      // Reset in cycle 10 aborts the operation; a start in the same cycle is lost.
      nd = 0;
      drive(1'b1, 3'b000, 32'd3, 32'd5, 5'd4);
      for (int c = 1; c <= 60; c++) begin
         tick();
         record(c);
         if (c == 11) begin
            chk("rst_busy_cleared", 32'(bus.busy), 32'd0);
            chk("rst_result_cleared", bus.result, 32'd0);
         end
         rst = (c == 10);
         if (c == 10)      drive(1'b1, 3'b100, 32'd9, 32'd2, 5'd7);
         else if (c == 12) drive(1'b1, 3'b111, 32'd10, 32'd3, 5'd5);
         else              drive(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
      end
      rst = 1'b0;
      chk("rst_done_count", 32'(nd), 32'd1);
      chk("rst_restart_cycle", 32'(dc[0]), 32'd45);
      chk("rst_restart_result", dr[0], 32'd1);
      chk("rst_restart_rd", 32'(dt[0]), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
